// File: rtl/trail_collision_reader_if.sv
// Frame-buffer read port: request/grant with fixed-latency read data.
// Latency: data returns a fixed number of cycles after an accepted request.
// Backpressure: the requester holds En and Addr until Gnt accepts the read.
interface trail_collision_reader_if;
  logic        Fb_Rd_En;
  logic [19:0] Fb_Rd_Addr;
  logic        Fb_Gnt;
  logic [15:0] Fb_Rd_Data;

  modport master (
    output Fb_Rd_En,
    output Fb_Rd_Addr,
    input  Fb_Gnt,
    input  Fb_Rd_Data
  );

  modport slave (
    input  Fb_Rd_En,
    input  Fb_Rd_Addr,
    output Fb_Gnt,
    output Fb_Rd_Data
  );
endinterface

// File: rtl/trail_collision_reader.sv
// Per-frame probe of the trail buffer one cell ahead of each bike; raises sticky crash flags.
// Latency: start cycle + CELL_WORDS accepted reads + READ_LAT drain per bike + 1 report cycle.
// Backpressure: Fb_Gnt low stalls ISSUE with En and Addr held; no read is lost or repeated.
module trail_collision_reader #(
  parameter int          OFFSET     = 20,
  parameter int          ROW_STRIDE = 1280,
  parameter int          CELL_WORDS = 2,
  parameter int          GRID_MAX   = 111,
  parameter int          READ_LAT   = 2,
  parameter logic [15:0] TRAIL_MASK = 16'h0F0F
) (
  input  logic                          Clk,
  input  logic                          Reset_n,
  input  logic                          frame_clk,
  input  logic [2:0]                    Game_State,
  input  logic [7:0]                    Blue_X,
  input  logic [7:0]                    Blue_Y,
  input  logic [7:0]                    Red_X,
  input  logic [7:0]                    Red_Y,
  input  logic [1:0]                    Blue_dir,
  input  logic [1:0]                    Red_dir,
  trail_collision_reader_if.master      fb,
  output logic                          Collision_Blue,
  output logic                          Collision_Red,
  output logic                          Check_Done
);

  localparam logic [2:0] PLAY  = 3'b010;
  localparam int         CNT_W = (CELL_WORDS > 1) ? $clog2(CELL_WORDS) : 1;

  typedef enum logic [2:0] {IDLE, B_ISSUE, B_DRAIN, R_ISSUE, R_DRAIN, REPORT} state_t;

  // One cell step along a single axis; the other axis passes through unchanged.
  function automatic logic signed [8:0] step(input logic [7:0] c, input logic [1:0] dir,
                                             input logic on_y);
    logic signed [8:0] v;
    v = signed'({1'b0, c});
    if (on_y && dir == 2'b00)       v = v - 9'sd1;
    else if (on_y && dir == 2'b01)  v = v + 9'sd1;
    else if (!on_y && dir == 2'b10) v = v - 9'sd1;
    else if (!on_y && dir == 2'b11) v = v + 9'sd1;
    return v;
  endfunction

  function automatic logic off_grid(input logic signed [8:0] x, input logic signed [8:0] y);
    return (x < 9'sd0) || (x > $signed(9'(GRID_MAX))) ||
           (y < 9'sd0) || (y > $signed(9'(GRID_MAX)));
  endfunction

  // Only evaluated for on-grid cells, so the low 8 bits carry the whole coordinate.
  function automatic logic [19:0] cell_base(input logic signed [8:0] x, input logic signed [8:0] y);
    return 20'((32'(y[7:0]) + 32'(OFFSET)) * 32'(ROW_STRIDE) +
               (32'(x[7:0]) + 32'(OFFSET)) * 32'(CELL_WORDS));
  endfunction

  state_t              state_q, state_n;
  logic                frame_prev_q;
  logic [19:0]         b_base_q, r_base_q;
  logic                r_wall_q;
  logic                b_hit_q, r_hit_q;
  logic                blue_flag_q, red_flag_q;
  logic [CNT_W-1:0]    word_cnt_q;
  logic [READ_LAT-1:0] vld_sr_q, vld_nxt;

  logic signed [8:0]   bx_p, by_p, rx_p, ry_p;
  logic                b_wall_c, r_wall_c, head_on_c;
  logic                play, start, accept, last_word, data_hit, in_blue;

  assign play      = (Game_State == PLAY);
  assign start     = frame_clk && !frame_prev_q && play && (state_q == IDLE);
  assign accept    = fb.Fb_Rd_En && fb.Fb_Gnt;
  assign last_word = (word_cnt_q == CNT_W'(CELL_WORDS - 1));
  assign vld_nxt   = (vld_sr_q << 1) | READ_LAT'(accept);
  assign data_hit  = vld_sr_q[READ_LAT-1] && ((fb.Fb_Rd_Data & TRAIL_MASK) != 16'h0000);
  assign in_blue   = (state_q == B_ISSUE) || (state_q == B_DRAIN);

  assign bx_p = step(Blue_X, Blue_dir, 1'b0);
  assign by_p = step(Blue_Y, Blue_dir, 1'b1);
  assign rx_p = step(Red_X,  Red_dir,  1'b0);
  assign ry_p = step(Red_Y,  Red_dir,  1'b1);

  assign b_wall_c  = off_grid(bx_p, by_p);
  assign r_wall_c  = off_grid(rx_p, ry_p);
  assign head_on_c = ((bx_p == rx_p) && (by_p == ry_p)) ||
                     ((bx_p == signed'({1'b0, Red_X}))  && (by_p == signed'({1'b0, Red_Y}))) ||
                     ((rx_p == signed'({1'b0, Blue_X})) && (ry_p == signed'({1'b0, Blue_Y})));

  // State register plus frame tick history for edge detection.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      frame_prev_q <= 1'b0;
    end else begin
      state_q      <= state_n;
      frame_prev_q <= frame_clk;
    end
  end

  // Next state, read request and report outputs; leaving play wins over everything.
  always_comb begin
    state_n        = state_q;
    fb.Fb_Rd_En    = 1'b0;
    fb.Fb_Rd_Addr  = 20'd0;
    Check_Done     = 1'b0;
    Collision_Blue = blue_flag_q;
    Collision_Red  = red_flag_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_n = !b_wall_c ? B_ISSUE : (!r_wall_c ? R_ISSUE : REPORT);
      end
      B_ISSUE: begin
        fb.Fb_Rd_En   = 1'b1;
        fb.Fb_Rd_Addr = b_base_q + 20'(word_cnt_q);
        if (accept && last_word) state_n = B_DRAIN;
      end
      B_DRAIN: begin
        if (vld_nxt == '0) state_n = r_wall_q ? REPORT : R_ISSUE;
      end
      R_ISSUE: begin
        fb.Fb_Rd_En   = 1'b1;
        fb.Fb_Rd_Addr = r_base_q + 20'(word_cnt_q);
        if (accept && last_word) state_n = R_DRAIN;
      end
      R_DRAIN: begin
        if (vld_nxt == '0) state_n = REPORT;
      end
      REPORT: begin
        Check_Done     = play;
        Collision_Blue = blue_flag_q | (play & b_hit_q);
        Collision_Red  = red_flag_q  | (play & r_hit_q);
        state_n        = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (!play) state_n = IDLE;
  end

  // Snapshot probe addresses at start; later position/direction changes are ignored.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      b_base_q <= 20'd0;
      r_base_q <= 20'd0;
      r_wall_q <= 1'b0;
    end else if (start) begin
      b_base_q <= cell_base(bx_p, by_p);
      r_base_q <= cell_base(rx_p, ry_p);
      r_wall_q <= r_wall_c;
    end
  end

  // Word counter within a cell and the in-flight read shift register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      word_cnt_q <= '0;
      vld_sr_q   <= '0;
    end else if (!play) begin
      word_cnt_q <= '0;
      vld_sr_q   <= '0;
    end else begin
      vld_sr_q <= vld_nxt;
      if (start)       word_cnt_q <= '0;
      else if (accept) word_cnt_q <= last_word ? '0 : word_cnt_q + CNT_W'(1);
    end
  end

  // Per-frame hits (wall, head-on, trail data) and sticky flags folded in at REPORT.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      b_hit_q     <= 1'b0;
      r_hit_q     <= 1'b0;
      blue_flag_q <= 1'b0;
      red_flag_q  <= 1'b0;
    end else if (!play) begin
      b_hit_q     <= 1'b0;
      r_hit_q     <= 1'b0;
      blue_flag_q <= 1'b0;
      red_flag_q  <= 1'b0;
    end else begin
      if (start) begin
        b_hit_q <= b_wall_c | head_on_c;
        r_hit_q <= r_wall_c | head_on_c;
      end else if (data_hit) begin
        if (in_blue) b_hit_q <= 1'b1;
        else         r_hit_q <= 1'b1;
      end
      if (state_q == REPORT) begin
        blue_flag_q <= blue_flag_q | b_hit_q;
        red_flag_q  <= red_flag_q  | r_hit_q;
      end
    end
  end

endmodule

// File: tb/tb_trail_collision_reader.sv
// Scoreboarded bench: stimulus queues expected read addresses and reports, a monitor compares.
// Frame-buffer model returns data two cycles after an accepted read, 16'hFFFF otherwise.
// Grant is driven by stimulus so stalls can be placed mid-issue.
module tb_trail_collision_reader;

  localparam logic [2:0] PLAY = 3'b010;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       frame_clk;
  logic [2:0] Game_State;
  logic [7:0] Blue_X, Blue_Y, Red_X, Red_Y;
  logic [1:0] Blue_dir, Red_dir;
  logic       Collision_Blue, Collision_Red, Check_Done;

  trail_collision_reader_if fb_if();

  trail_collision_reader dut (
    .Clk            (Clk),
    .Reset_n        (Reset_n),
    .frame_clk      (frame_clk),
    .Game_State     (Game_State),
    .Blue_X         (Blue_X),
    .Blue_Y         (Blue_Y),
    .Red_X          (Red_X),
    .Red_Y          (Red_Y),
    .Blue_dir       (Blue_dir),
    .Red_dir        (Red_dir),
    .fb             (fb_if),
    .Collision_Blue (Collision_Blue),
    .Collision_Red  (Collision_Red),
    .Check_Done     (Check_Done)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_bad = 0;
  int acc_cnt = 0;
  int done_cnt = 0;
  int exp_done = 0;

  int         exp_addr[$];
  logic [1:0] exp_rep[$];
  logic [15:0] mem [int];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s", name);
  endtask

  // Frame-buffer read port model with fixed two-cycle latency.
  logic p1_v = 1'b0;
  int   p1_a = 0;
  always @(posedge Clk) begin
    p1_v <= fb_if.Fb_Rd_En & fb_if.Fb_Gnt;
    p1_a <= int'(fb_if.Fb_Rd_Addr);
    fb_if.Fb_Rd_Data <= p1_v ? (mem.exists(p1_a) ? mem[p1_a] : 16'h0000) : 16'hFFFF;
  end

  // Monitor: compares accepted reads, held addresses under stall, and reports.
  always @(negedge Clk) begin
    if (Reset_n === 1'b1) begin
      if (fb_if.Fb_Rd_En && fb_if.Fb_Gnt) begin
        acc_cnt++;
        if (exp_addr.size() == 0) fail("unexpected_read");
        else chk("rd_addr", 32'(fb_if.Fb_Rd_Addr), 32'(exp_addr.pop_front()));
      end else if (fb_if.Fb_Rd_En && !fb_if.Fb_Gnt && exp_addr.size() != 0) begin
        chk("rd_addr_hold", 32'(fb_if.Fb_Rd_Addr), 32'(exp_addr[0]));
      end
      if (Check_Done) begin
        done_cnt++;
        if (exp_rep.size() == 0) fail("unexpected_check_done");
        else chk("flags_blue_red", 32'({Collision_Blue, Collision_Red}), 32'(exp_rep.pop_front()));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  // Start a frame, then scramble inputs to show they are ignored after the start cycle.
  task automatic frame(input logic [7:0] bx, input logic [7:0] by, input logic [1:0] bd,
                       input logic [7:0] rx, input logic [7:0] ry, input logic [1:0] rd);
    Blue_X = bx; Blue_Y = by; Blue_dir = bd;
    Red_X  = rx; Red_Y  = ry; Red_dir  = rd;
    frame_clk = 1'b1;
    tick(1);
    Blue_X = bx ^ 8'h55; Blue_Y = by + 8'd7; Blue_dir = ~bd;
    Red_X  = rx ^ 8'h33; Red_Y  = ry - 8'd9; Red_dir  = ~rd;
    frame_clk = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    exp_done++;
    while (done_cnt < exp_done && n < 300) begin
      tick(1);
      n++;
    end
    if (done_cnt < exp_done) fail({name, "_timeout"});
    tick(2);
  endtask

  task automatic clear_game();
    Game_State = 3'b000;
    tick(2);
    chk("cleared_blue", 32'(Collision_Blue), 32'd0);
    chk("cleared_red",  32'(Collision_Red),  32'd0);
    Game_State = PLAY;
    tick(2);
  endtask

  initial begin
    int target;
    int n;
    Reset_n = 1'b0; frame_clk = 1'b0; Game_State = 3'b000; fb_if.Fb_Gnt = 1'b1;
    Blue_X = 8'd0; Blue_Y = 8'd0; Red_X = 8'd0; Red_Y = 8'd0; Blue_dir = 2'b00; Red_dir = 2'b00;
    tick(3);
    chk("rst_rd_en",   32'(fb_if.Fb_Rd_En),   32'd0);
    chk("rst_rd_addr", 32'(fb_if.Fb_Rd_Addr), 32'd0);
    chk("rst_col_blue", 32'(Collision_Blue),  32'd0);
    chk("rst_col_red",  32'(Collision_Red),   32'd0);
    chk("rst_done",     32'(Check_Done),      32'd0);
    Reset_n = 1'b1;
    tick(2);
    Game_State = PLAY;
    tick(2);

    // Clear buffer: blue (10,10) right -> cell (11,10); red (50,60) up -> cell (50,59).
    exp_addr.push_back(38462); exp_addr.push_back(38463);
    exp_addr.push_back(101260); exp_addr.push_back(101261);
    exp_rep.push_back(2'b00);
    frame(8'd10, 8'd10, 2'b11, 8'd50, 8'd60, 2'b00);
    wait_done("clear_frame");

    // Trail bits in the second word of red's probe cell.
    mem[101261] = 16'h0300;
    exp_addr.push_back(38462); exp_addr.push_back(38463);
    exp_addr.push_back(101260); exp_addr.push_back(101261);
    exp_rep.push_back(2'b01);
    frame(8'd10, 8'd10, 2'b11, 8'd50, 8'd60, 2'b00);
    wait_done("red_trail");
    clear_game();

    // Blue runs off the left edge: only red's (30,31) cell is read.
    exp_addr.push_back(65380); exp_addr.push_back(65381);
    exp_rep.push_back(2'b10);
    frame(8'd0, 8'd5, 2'b10, 8'd30, 8'd30, 2'b01);
    wait_done("blue_wall");
    clear_game();

    // Both bikes probe (21,20).
    exp_addr.push_back(51282); exp_addr.push_back(51283);
    exp_addr.push_back(51282); exp_addr.push_back(51283);
    exp_rep.push_back(2'b11);
    frame(8'd20, 8'd20, 2'b11, 8'd22, 8'd20, 2'b10);
    wait_done("head_on");
    clear_game();

    // Grant stalls for 5 cycles after blue's first accepted read; non-trail data.
    mem[38462] = 16'hF0F0; mem[38463] = 16'hF0F0;
    exp_addr.push_back(38462); exp_addr.push_back(38463);
    exp_addr.push_back(65380); exp_addr.push_back(65381);
    exp_rep.push_back(2'b00);
    frame(8'd10, 8'd10, 2'b11, 8'd30, 8'd30, 2'b01);
    tick(1);
    fb_if.Fb_Gnt = 1'b0;
    tick(5);
    fb_if.Fb_Gnt = 1'b1;
    wait_done("gnt_stall");

    // Leave play during R_DRAIN: no report, flags clear, late trail data dropped.
    exp_addr.push_back(38462); exp_addr.push_back(38463);
    exp_addr.push_back(101260); exp_addr.push_back(101261);
    target = acc_cnt + 4;
    frame(8'd10, 8'd10, 2'b11, 8'd50, 8'd60, 2'b00);
    n = 0;
    while (acc_cnt < target && n < 100) begin
      tick(1);
      n++;
    end
    if (acc_cnt < target) fail("abort_reads_timeout");
    Game_State = 3'b000;
    tick(4);
    chk("abort_col_blue", 32'(Collision_Blue), 32'd0);
    chk("abort_col_red",  32'(Collision_Red),  32'd0);
    chk("abort_no_done",  32'(done_cnt),       32'(exp_done));
    Game_State = PLAY;
    tick(2);

    // Normal frame after the abort starts fresh.
    exp_addr.push_back(38462); exp_addr.push_back(38463);
    exp_addr.push_back(65380); exp_addr.push_back(65381);
    exp_rep.push_back(2'b00);
    frame(8'd10, 8'd10, 2'b11, 8'd30, 8'd30, 2'b01);
    wait_done("after_abort");

    tick(5);
    chk("addr_queue_left", 32'(exp_addr.size()), 32'd0);
    chk("rep_queue_left",  32'(exp_rep.size()),  32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
